imem_refill: RTL and testbench
==============================

IMEM_REFILL -- requirements
Module: imem_refill

Interface
REQ-001 The block SHALL have parameter LINE_WORDS, default 4, meaning words per cache line; legal values are powers of two from 2 to 16.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit; reset is synchronous and active-low.
REQ-004 The block SHALL have port miss_req, input, 1 bit, a level from fetch: the instruction lookup missed.
REQ-005 The block SHALL have port miss_addr, input, 32 bits, the byte address of the missed instruction.
REQ-006 The block SHALL have port mem_req, output, 1 bit, a read request to backing memory.
REQ-007 The block SHALL have port mem_addr, output, 32 bits, the word-aligned byte address of the request.
REQ-008 The block SHALL have port mem_ack, input, 1 bit; memory accepted the request this cycle.
REQ-009 The block SHALL have ports mem_rvalid, input, 1 bit, and mem_rdata, input, 32 bits, the read-data return.
REQ-010 The block SHALL have ports fill_we, output, 1 bit; fill_addr, output, 32 bits; and fill_data, output, 32 bits; together they form the cache-array write port.
REQ-011 The block SHALL have port miss_done, output, 1 bit, a one-cycle pulse meaning the line is complete and fetch may retry.
REQ-012 The block SHALL have port busy, output, 1 bit, high in every state except IDLE.

Function
REQ-013 The FSM SHALL have the states IDLE, REQ, WAIT and DONE.
REQ-014 In IDLE with miss_req=1, the block SHALL latch base = miss_addr with the low log2(LINE_WORDS)+2 bits cleared, latch start = miss_addr word offset, clear cnt, and go to REQ on the next cycle.
REQ-015 The block SHALL fetch words in critical-word-first order; word i SHALL be at offset (start+i) mod LINE_WORDS, wrapping within the line and never crossing into the next line.
REQ-016 In REQ, mem_req SHALL be 1 and mem_addr SHALL be base + 4*((start+cnt) mod LINE_WORDS); both SHALL be held stable until mem_ack=1, then the FSM SHALL go to WAIT.
REQ-017 In WAIT, mem_req SHALL be 0; on mem_rvalid=1 the block SHALL drive fill_we=1, fill_addr=the requested address and fill_data=mem_rdata in that same cycle (combinational, 0-cycle latency), then increment cnt.
REQ-018 After a WAIT beat with cnt=LINE_WORDS-1, the FSM SHALL go to DONE; otherwise it SHALL return to REQ.
REQ-019 DONE SHALL last exactly one cycle with miss_done=1, then the FSM SHALL go to IDLE; a new miss SHALL not be accepted in the DONE cycle.
REQ-020 mem_rvalid outside WAIT SHALL be ignored: no fill write and no counter change.
REQ-021 mem_ack outside REQ SHALL be ignored.
REQ-022 Deasserting miss_req mid-refill SHALL not abort the refill; the whole line is fetched and miss_done still pulses.
REQ-023 miss_addr changes after acceptance SHALL be ignored until the next IDLE acceptance.
REQ-024 Exactly LINE_WORDS fill_we pulses and LINE_WORDS mem_ack handshakes SHALL occur per refill.
REQ-025 fill_addr and fill_data SHALL be 0 whenever fill_we=0.
REQ-026 Minimum refill latency from miss acceptance to miss_done SHALL be 2*LINE_WORDS+2 cycles when mem_ack and mem_rvalid each arrive on the first eligible cycle.

Reset
REQ-027 While rst_n=0 at a clock edge, the FSM SHALL go to IDLE with cnt=0, base=0 and start=0.
REQ-028 Reset values of all outputs SHALL be mem_req=0, mem_addr=0, fill_we=0, fill_addr=0, fill_data=0, miss_done=0 and busy=0.
REQ-029 Reset mid-refill SHALL abandon the line with no further fill_we or miss_done; a later mem_rvalid SHALL be ignored.

Verification
REQ-030 The bench SHALL cover: miss_addr=0x0000_0104, LINE_WORDS=4, immediate ack/rvalid -> mem_addr sequence 0x104, 0x108, 0x10C, 0x100; fill_we ×4; miss_done pulse 10 cycles after acceptance.
REQ-031 The bench SHALL cover: miss_addr=0x0000_0200, mem_ack delayed 3 cycles per word -> mem_addr held stable while waiting; order 0x200, 0x204, 0x208, 0x20C.
REQ-032 The bench SHALL cover: a spurious mem_rvalid=1 with mem_rdata=0xDEAD_BEEF in IDLE and in REQ -> no fill_we and no counter advance.
REQ-033 The bench SHALL cover: miss_req dropped after the first word -> all 4 words are still filled and miss_done pulses once.
REQ-034 The bench SHALL cover: rst_n=0 after 2 words -> the next cycle has busy=0, mem_req=0 and fill_we=0; a new miss at 0x0000_0040 then refills correctly.
REQ-035 The bench SHALL cover: miss_req held high through DONE -> the next acceptance occurs on the cycle after IDLE is re-entered, not during DONE.

Source files
------------

// File: rtl/imem_refill.sv
// Instruction-cache line refill engine.
// On a fetch miss it reads one cache line from backing memory one word at a
// time, critical word first, and writes each returned word straight into the
// cache array. miss_done pulses for one cycle once the whole line is written.
module imem_refill #(
  parameter int LINE_WORDS = 4  // words per line; power of two, 2..16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        miss_req,
  input  logic [31:0] miss_addr,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        fill_we,
  output logic [31:0] fill_addr,
  output logic [31:0] fill_data,
  output logic        miss_done,
  output logic        busy
);

  // Word-offset width within a line, and the number of byte-address bits
  // that the line base clears.
  localparam int OFF_W  = $clog2(LINE_WORDS);
  localparam int LINE_B = OFF_W + 2;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_t;

  state_t            state, state_nxt;
  logic [31:0]       base, base_nxt;
  logic [OFF_W-1:0]  start, start_nxt;
  logic [OFF_W-1:0]  cnt, cnt_nxt;
  logic [OFF_W-1:0]  word_off;
  logic [31:0]       word_addr;

  // The two byte-select bits of the miss address never matter: every
  // request is word aligned.
  logic              unused_byte_sel;
  assign unused_byte_sel = ^miss_addr[1:0];

  // Critical-word-first order: the offset is summed in OFF_W bits, so it wraps
  // inside the line and can never carry into the next line's base.
  assign word_off  = start + cnt;
  assign word_addr = {base[31:LINE_B], word_off, 2'b00};

  // State and refill-context registers with synchronous active-low reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before this edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      base  <= '0;
      start <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      base  <= base_nxt;
      start <= start_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic and all outputs; the fill write is combinational from
  // mem_rvalid so a returned word reaches the array in the same cycle.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_nxt = state;
    base_nxt  = base;
    start_nxt = start;
    cnt_nxt   = cnt;
    mem_req   = 1'b0;
    mem_addr  = '0;
    fill_we   = 1'b0;
    fill_addr = '0;
    fill_data = '0;
    miss_done = 1'b0;

    case (state)
      IDLE: begin
        if (miss_req) begin
          base_nxt  = {miss_addr[31:LINE_B], {LINE_B{1'b0}}};
          start_nxt = miss_addr[LINE_B-1:2];
          cnt_nxt   = '0;
          state_nxt = REQ;
        end
      end
      REQ: begin
        mem_req  = 1'b1;
        mem_addr = word_addr;
        if (mem_ack) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          fill_we   = 1'b1;
          fill_addr = word_addr;
          fill_data = mem_rdata;
          cnt_nxt   = cnt + 1'b1;
          // The last word has every offset-count bit set.
          state_nxt = (&cnt) ? DONE : REQ;
        end
      end
      DONE: begin
        miss_done = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // busy is simply "not idle"; it covers the DONE cycle too.
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_imem_refill.sv
// Directed bench for imem_refill with LINE_WORDS = 4. A procedural memory
// responder answers requests with configurable ack delay, and every expected
// address is derived here from the miss address.
module tb_imem_refill;

  localparam int LW = 4;

  logic        clk;
  logic        rst_n;
  logic        miss_req;
  logic [31:0] miss_addr;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        fill_we;
  logic [31:0] fill_addr;
  logic [31:0] fill_data;
  logic        miss_done;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int fill_cnt = 0;
  int done_cnt = 0;

  imem_refill #(.LINE_WORDS(LW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .miss_req   (miss_req),
    .miss_addr  (miss_addr),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .fill_we    (fill_we),
    .fill_addr  (fill_addr),
    .fill_data  (fill_data),
    .miss_done  (miss_done),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count fill writes and done pulses mid-cycle, away from the clock edge.
  always @(negedge clk) begin
    if (fill_we)   fill_cnt = fill_cnt + 1;
    if (miss_done) done_cnt = done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One refill of the line holding addr. ack_dly idle REQ cycles before each
  // ack; miss_req drops after drop_at words; spurious injects rvalid in REQ and
  // ack in WAIT; abort_after resets after that many words; hold keeps miss_req
  // high through DONE with a new address presented.
  task automatic run_refill(input logic [31:0] addr, input int ack_dly, input int drop_at,
                            input bit spurious, input int abort_after, input bit hold);
    logic [31:0] base;
    logic [31:0] ea;
    int start;
    int fills0;
    int dones0;
    base   = addr & ~32'h0000_000F;
    start  = int'((addr >> 2) & 32'h3);
    fills0 = fill_cnt;
    dones0 = done_cnt;

    miss_req  = 1'b1;
    miss_addr = addr;
    #1;
    check("idle_busy", 32'(busy), 0);
    tick();
    // Address changes after acceptance must not disturb the line.
    miss_addr = 32'hFFFF_FFFC;
    if (drop_at == 0) miss_req = 1'b0;

    for (int i = 0; i < LW; i++) begin
      ea = base + 32'(4 * ((start + i) % LW));
      if (i == abort_after) begin
        rst_n    = 1'b0;
        miss_req = 1'b0;
        tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_fill_we", 32'(fill_we), 0);
        rst_n      = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        #1;
        check("late_rvalid_we", 32'(fill_we), 0);
        check("late_rvalid_addr", fill_addr, 0);
        tick();
        mem_rvalid = 1'b0;
        check("abort_fills", 32'(fill_cnt - fills0), 32'(abort_after));
        check("abort_no_done", 32'(done_cnt - dones0), 0);
        return;
      end
      for (int d = 0; d < ack_dly; d++) begin
        mem_ack = 1'b0;
        if (spurious) begin
          mem_rvalid = 1'b1;
          mem_rdata  = 32'hDEAD_BEEF;
        end
        #1;
        check("req_hold", 32'(mem_req), 1);
        check("addr_hold", mem_addr, ea);
        check("req_no_fill", 32'(fill_we), 0);
        tick();
        mem_rvalid = 1'b0;
      end
      mem_ack = 1'b1;
      #1;
      check("req", 32'(mem_req), 1);
      check("mem_addr", mem_addr, ea);
      tick();
      mem_ack = 1'b0;
      if (spurious) begin
        // An ack in WAIT must not move the FSM or produce a write.
        mem_ack = 1'b1;
        #1;
        check("wait_ack_req", 32'(mem_req), 0);
        check("wait_ack_we", 32'(fill_we), 0);
        tick();
        mem_ack = 1'b0;
      end
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hC0DE_0000 ^ ea;
      #1;
      check("wait_req_low", 32'(mem_req), 0);
      check("fill_we", 32'(fill_we), 1);
      check("fill_addr", fill_addr, ea);
      check("fill_data", fill_data, 32'hC0DE_0000 ^ ea);
      check("no_early_done", 32'(miss_done), 0);
      tick();
      mem_rvalid = 1'b0;
      if (i + 1 == drop_at) miss_req = 1'b0;
    end

    // With immediate ack/rvalid this is the tenth cycle counting the
    // acceptance cycle.
    if (hold) begin
      miss_req  = 1'b1;
      miss_addr = 32'h0000_0600;
    end else begin
      miss_req = 1'b0;
    end
    #1;
    check("done_pulse", 32'(miss_done), 1);
    check("done_busy", 32'(busy), 1);
    check("done_no_req", 32'(mem_req), 0);
    tick();
    check("done_one_cycle", 32'(miss_done), 0);
    check("idle_after_done", 32'(busy), 0);
    check("idle_no_req", 32'(mem_req), 0);
    check("fill_count", 32'(fill_cnt - fills0), LW);
    check("done_count", 32'(done_cnt - dones0), 1);
    if (hold) begin
      tick();
      check("reaccept_req", 32'(mem_req), 1);
      check("reaccept_addr", mem_addr, 32'h0000_0600);
      rst_n    = 1'b0;
      miss_req = 1'b0;
      tick();
      rst_n = 1'b1;
    end
  endtask

  // Bound the run in case the DUT stalls a handshake forever.
  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n      = 1'b0;
    miss_req   = 1'b0;
    miss_addr  = '0;
    mem_ack    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    tick();
    tick();
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_fill_we", 32'(fill_we), 0);
    check("rst_fill_addr", fill_addr, 0);
    check("rst_fill_data", fill_data, 0);
    check("rst_miss_done", 32'(miss_done), 0);
    check("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    tick();

    // Critical word first from offset 1: 0x104, 0x108, 0x10C, 0x100.
    run_refill(32'h0000_0104, 0, 0, 1'b0, LW, 1'b0);
    // Slow memory: ack three cycles late, address held meanwhile.
    run_refill(32'h0000_0200, 3, 0, 1'b0, LW, 1'b0);

    // Spurious read data while idle.
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEAD_BEEF;
    #1;
    check("idle_rvalid_we", 32'(fill_we), 0);
    check("idle_rvalid_addr", fill_addr, 0);
    check("idle_rvalid_data", fill_data, 0);
    tick();
    mem_rvalid = 1'b0;
    // Spurious rvalid in REQ and ack in WAIT; order 0x308, 0x30C, 0x300, 0x304.
    run_refill(32'h0000_0308, 1, 0, 1'b1, LW, 1'b0);

    // miss_req dropped after the first word.
    run_refill(32'h0000_0410, 0, 1, 1'b0, LW, 1'b0);

    // Reset after two words, then a clean refill at 0x40.
    run_refill(32'h0000_0500, 0, LW, 1'b0, 2, 1'b0);
    run_refill(32'h0000_0040, 0, 0, 1'b0, LW, 1'b0);

    // miss_req held through DONE: acceptance only once IDLE is re-entered.
    run_refill(32'h0000_070C, 0, LW, 1'b0, LW, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
